// File: rtl/ysyx_23060201_gpr_sb_pkg.sv
// Shared defaults and types for the GPR file with write scoreboard.
package ysyx_23060201_gpr_sb_pkg;

  localparam int unsigned GPR_ADDR_WIDTH = 5;
  localparam int unsigned GPR_DATA_WIDTH = 32;
  localparam int unsigned GPR_NR_READ    = 2;
  localparam int unsigned GPR_ZERO_IDX   = 0;

  typedef enum logic [1:0] {
    SRC_NONE   = 2'd0,
    SRC_BYPASS = 2'd1,
    SRC_ARRAY  = 2'd2
  } rd_src_e;

endpackage

// File: rtl/ysyx_23060201_gpr_sb_scoreboard.sv
// Per-register pending-writer tracking: allocation from issue, release from writeback.
module ysyx_23060201_scoreboard
  import ysyx_23060201_gpr_sb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = GPR_ADDR_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic                         wr_release,
  input  logic                         alloc_en,
  input  logic [ADDR_WIDTH-1:0]        alloc_addr,
  output logic                         alloc_ok,
  output logic [(1<<ADDR_WIDTH)-1:0]   busy
);

  localparam logic [ADDR_WIDTH-1:0] ZERO = ADDR_WIDTH'(GPR_ZERO_IDX);

  logic [(1<<ADDR_WIDTH)-1:0] busy_q;
  logic                       rel_valid;

  assign rel_valid = wr_en && wr_release && (wr_addr != ZERO);
  assign alloc_ok  = alloc_en && ((alloc_addr == ZERO) || !busy_q[alloc_addr] ||
                                  (rel_valid && (wr_addr == alloc_addr)));
  assign busy      = busy_q;

  // Set is ordered after clear so a same-index alloc keeps the register owned.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      if (rel_valid)
        busy_q[wr_addr] <= 1'b0;
      if (alloc_ok && (alloc_addr != ZERO))
        busy_q[alloc_addr] <= 1'b1;
    end
  end

endmodule

// File: rtl/ysyx_23060201_gpr_sb.sv
// Register file with configurable read ports, optional writeback bypass and RAW scoreboard.
module ysyx_23060201_gpr_sb
  import ysyx_23060201_gpr_sb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = GPR_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = GPR_DATA_WIDTH,
  parameter int unsigned NR_READ    = GPR_NR_READ,
  parameter int unsigned BYPASS     = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NR_READ-1:0]            rd_en,
  input  logic [NR_READ*ADDR_WIDTH-1:0] rd_addr,
  output logic [NR_READ*DATA_WIDTH-1:0] rd_data,
  output logic [NR_READ-1:0]            rd_busy,
  input  logic                          wr_en,
  input  logic [ADDR_WIDTH-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          wr_release,
  input  logic                          alloc_en,
  input  logic [ADDR_WIDTH-1:0]         alloc_addr,
  output logic                          alloc_ok
);

  localparam int unsigned           DEPTH  = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO   = ADDR_WIDTH'(GPR_ZERO_IDX);
  localparam logic                  BYP_ON = (BYPASS != 0);

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      busy;

  ysyx_23060201_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_release (wr_release),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .alloc_ok   (alloc_ok),
    .busy       (busy)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        regs[i] <= '0;
    end else if (wr_en && (wr_addr != ZERO)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  for (genvar i = 0; i < NR_READ; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] addr;
    logic                  wr_hit;
    rd_src_e               src;
    logic [DATA_WIDTH-1:0] data;

    assign addr   = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign wr_hit = BYP_ON && wr_en && (wr_addr == addr);

    // Index 0 never reaches the array path, so it reads 0 and is never busy.
    always_comb begin
      src = SRC_NONE;
      if (rd_en[i] && (addr != ZERO))
        src = wr_hit ? SRC_BYPASS : SRC_ARRAY;
    end

    always_comb begin
      data = '0;
      case (src)
        SRC_BYPASS: data = wr_data;
        SRC_ARRAY:  data = regs[addr];
        default:    data = '0;
      endcase
    end

    assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] = data;
    assign rd_busy[i] = (src != SRC_NONE) && busy[addr] && !(wr_hit && wr_release);
  end

endmodule

// File: tb/tb_ysyx_23060201_gpr_sb.sv
// Scoreboard bench: a 3-port bypassing instance and a 2-port non-bypassing instance share stimulus.
module tb_ysyx_23060201_gpr_sb;

  logic        clk;
  logic        rst;
  logic [2:0]  rd_en;
  logic [14:0] rd_addr;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_release;
  logic        alloc_en;
  logic [4:0]  alloc_addr;

  logic [95:0] a_rd_data;
  logic [2:0]  a_rd_busy;
  logic        a_alloc_ok;
  logic [63:0] b_rd_data;
  logic [1:0]  b_rd_busy;
  logic        b_alloc_ok;

  ysyx_23060201_gpr_sb #(
    .ADDR_WIDTH (5),
    .DATA_WIDTH (32),
    .NR_READ    (3),
    .BYPASS     (1)
  ) dut_a (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (a_rd_data),
    .rd_busy    (a_rd_busy),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_release (wr_release),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .alloc_ok   (a_alloc_ok)
  );

  ysyx_23060201_gpr_sb #(
    .ADDR_WIDTH (5),
    .DATA_WIDTH (32),
    .NR_READ    (2),
    .BYPASS     (0)
  ) dut_b (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (rd_en[1:0]),
    .rd_addr    (rd_addr[9:0]),
    .rd_data    (b_rd_data),
    .rd_busy    (b_rd_busy),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_release (wr_release),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .alloc_ok   (b_alloc_ok)
  );

  typedef struct {
    logic [95:0] a_data;
    logic [2:0]  a_busy;
    logic        a_ok;
    logic [63:0] b_data;
    logic [1:0]  b_busy;
    logic        b_ok;
  } exp_t;

  exp_t        exp_q[$];
  int          checks;
  int          failures;
  bit          model_valid;
  logic [31:0] m_mem  [32];
  bit          m_busy [32];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Architectural view of one read port, taken from the current model state.
  function automatic void port_exp(input bit bp, input logic en, input logic [4:0] a,
                                   output logic [31:0] d, output logic b);
    d = '0;
    b = 1'b0;
    if (en && a != 5'd0) begin
      if (bp && wr_en && wr_addr == a) d = wr_data;
      else                             d = m_mem[a];
      b = m_busy[a] && !(bp && wr_en && wr_release && wr_addr == a);
    end
  endfunction

  task automatic drive(input logic r, input logic [2:0] re,
                       input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic rel, input logic ae, input logic [4:0] aa);
    exp_t        e;
    logic [31:0] d;
    logic        b;
    logic [4:0]  addrs [3];
    bit          ok;
    @(negedge clk);
    rst        = r;
    rd_en      = re;
    rd_addr    = {a2, a1, a0};
    wr_en      = we;
    wr_addr    = wa;
    wr_data    = wd;
    wr_release = rel;
    alloc_en   = ae;
    alloc_addr = aa;
    addrs[0] = a0; addrs[1] = a1; addrs[2] = a2;
    ok = ae && (aa == 5'd0 || !m_busy[aa] || (we && rel && wa == aa));
    for (int i = 0; i < 3; i++) begin
      port_exp(1'b1, re[i], addrs[i], d, b);
      e.a_data[i*32 +: 32] = d;
      e.a_busy[i]          = b;
    end
    for (int i = 0; i < 2; i++) begin
      port_exp(1'b0, re[i], addrs[i], d, b);
      e.b_data[i*32 +: 32] = d;
      e.b_busy[i]          = b;
    end
    e.a_ok = ok;
    e.b_ok = ok;
    if (model_valid) exp_q.push_back(e);
    // State after the coming rising edge.
    if (r) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[i]  = '0;
        m_busy[i] = 1'b0;
      end
      model_valid = 1'b1;
    end else begin
      if (we && wa != 5'd0) m_mem[wa] = wd;
      if (we && rel && wa != 5'd0) m_busy[wa] = 1'b0;
      if (ok && aa != 5'd0) m_busy[aa] = 1'b1;
    end
  endtask

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("a_rd_data",  96'(a_rd_data),  96'(e.a_data));
        chk("a_rd_busy",  96'(a_rd_busy),  96'(e.a_busy));
        chk("a_alloc_ok", 96'(a_alloc_ok), 96'(e.a_ok));
        chk("b_rd_data",  96'(b_rd_data),  96'(e.b_data));
        chk("b_rd_busy",  96'(b_rd_busy),  96'(e.b_busy));
        chk("b_alloc_ok", 96'(b_alloc_ok), 96'(e.b_ok));
      end
    end
  end

  function automatic logic [4:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin : stim
    int waited;
    checks      = 0;
    failures    = 0;
    model_valid = 1'b0;
    rst = 1'b1; rd_en = '0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0;
    wr_data = '0; wr_release = 1'b0; alloc_en = 1'b0; alloc_addr = '0;

    drive(1, 3'b000, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0);
    drive(1, 3'b111, 5, 31, 5, 0, 0, 32'h0, 0, 0, 0);
    drive(0, 3'b111, 5, 31, 31, 0, 0, 32'h0, 0, 0, 0);
    drive(0, 3'b111, 31, 5, 3, 0, 0, 32'h0, 0, 0, 0);
    drive(0, 3'b111, 3, 3, 3, 1, 3, 32'hDEADBEEF, 0, 0, 0);
    drive(0, 3'b111, 3, 3, 3, 0, 0, 32'h0, 0, 0, 0);
    drive(0, 3'b111, 0, 0, 0, 1, 0, 32'h12345678, 0, 0, 0);
    drive(0, 3'b111, 0, 0, 0, 0, 0, 32'h0, 0, 1, 0);
    drive(0, 3'b111, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0);
    drive(0, 3'b111, 7, 7, 7, 0, 0, 32'h0, 0, 1, 7);
    drive(0, 3'b111, 7, 7, 7, 0, 0, 32'h0, 0, 1, 7);
    drive(0, 3'b111, 7, 7, 7, 1, 7, 32'hA5, 1, 0, 0);
    drive(0, 3'b111, 7, 7, 7, 0, 0, 32'h0, 0, 1, 7);
    drive(0, 3'b111, 9, 9, 9, 0, 0, 32'h0, 0, 1, 9);
    drive(0, 3'b111, 9, 9, 9, 1, 9, 32'h99, 1, 1, 9);
    drive(0, 3'b111, 9, 9, 9, 0, 0, 32'h0, 0, 1, 9);
    drive(0, 3'b111, 4, 4, 4, 0, 0, 32'h0, 0, 1, 4);
    drive(0, 3'b111, 4, 4, 4, 1, 4, 32'h44, 0, 0, 0);
    drive(1, 3'b111, 4, 4, 4, 1, 4, 32'hFF, 1, 1, 4);
    drive(0, 3'b111, 4, 4, 4, 0, 0, 32'h0, 0, 1, 4);
    drive(0, 3'b111, 4, 4, 4, 1, 4, 32'h0, 1, 0, 0);
    drive(0, 3'b101, 4, 9, 7, 1, 0, 32'h1, 1, 0, 0);

    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 99) == 0),
            3'($urandom),
            rnd_addr(), rnd_addr(), rnd_addr(),
            ($urandom_range(0, 2) != 0), rnd_addr(), $urandom,
            ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 2) != 0), rnd_addr());
    end
    drive(0, 3'b000, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0);

    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain actual=%0d required=0 entries left", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
